regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port (wen/rd/dataD) between two writeback requesters: port 0 (ALU) and port 1 (LSU).
- Round-robin arbitration with a registered output stage driving the register file.
- Per-register pending scoreboard, set at issue and cleared at writeback, so decode can stall on RAW hazards.
- Sits between the execute/memory stages and register_file.

Parameters:
ADDR_WIDTH, 5, register index width; register count = 1<<ADDR_WIDTH
DATA_WIDTH, 32, register data width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
req0_valid  input  1  port 0 has a writeback
req0_ready  output  1  port 0 writeback accepted this cycle
req0_rd  input  ADDR_WIDTH  port 0 destination register
req0_data  input  DATA_WIDTH  port 0 write data
req1_valid  input  1  port 1 has a writeback
req1_ready  output  1  port 1 writeback accepted this cycle
req1_rd  input  ADDR_WIDTH  port 1 destination register
req1_data  input  DATA_WIDTH  port 1 write data
rf_wen  output  1  register-file write enable (registered)
rf_rd  output  ADDR_WIDTH  register-file write index (registered)
rf_data  output  DATA_WIDTH  register-file write data (registered)
iss_valid  input  1  an instruction with a destination issues this cycle
iss_rd  input  ADDR_WIDTH  destination of the issuing instruction
rs1  input  ADDR_WIDTH  hazard query index 1
rs2  input  ADDR_WIDTH  hazard query index 2
rs1_busy  output  1  rs1 has a pending write
rs2_busy  output  1  rs2 has a pending write
last_grant  output  1  port granted most recently (registered)

Behaviour:
Reset (rst=1 at posedge):
- rf_wen=0, rf_rd=0, rf_data=0.
- pending[*]=0.
- last_grant=1, so port 0 wins the first tie.
- Reset overrides any same-cycle request or issue; an in-flight write is dropped.

Arbitration (combinational within the cycle):
- Only one port valid: that port is granted.
- Both valid: grant = ~last_grant.
- Neither valid: no grant.
- reqN_ready = grant to N. No backpressure from the register file; the granted port is always accepted.
- A losing requester sees ready=0 and must hold valid, rd and data stable until accepted.

Transfer (at posedge with grant, one-cycle latency):
- rf_rd <= granted rd; rf_data <= granted data; last_grant <= granted port.
- rf_wen <= 1 only if granted rd != 0.
- rd==0 writeback: accepted (ready=1) and last_grant updates, but rf_wen=0.

No grant:
- rf_wen <= 0; rf_rd/rf_data hold; last_grant holds.
- rf_wen is high for exactly one cycle per accepted nonzero write. Back-to-back grants give rf_wen high on consecutive cycles.

Scoreboard (at posedge):
- Clear pending[rd] when a writeback to rd != 0 is granted.
- Set pending[iss_rd] when iss_valid and iss_rd != 0.
- Same register set and cleared in one cycle: set wins (newer producer).
- pending[0] is constant 0.

Busy (combinational from registered state):
- rsN_busy = pending[rsN]; 0 when rsN==0.
- A grant in the current cycle does not clear busy until the next cycle. Forwarding is the pipeline's responsibility.

Optional Feature:
Macro WB_TRACE_EN.
- Defined: at each posedge with a grant, $display "wb x%0d <= %x (port %0d)". If the granted nonzero rd was not pending, $display "WB WARN: x%0d not pending".
- Undefined: no simulation output; all functional behaviour identical.

Test Plan:
- Reset, then req0 only (rd=5, data=0x11) -> req0_ready=1 same cycle; next cycle rf_wen=1, rf_rd=5, rf_data=0x11; following cycle rf_wen=0.
- Both valid for 4 cycles (req0 rd=1/0xA, req1 rd=2/0xB, each deasserting after acceptance) -> grants port 0 then port 1; rf writes x1=0xA then x2=0xB on consecutive cycles.
- req1 rd=0 data=0xFF -> req1_ready=1, rf_wen stays 0 next cycle, last_grant=1.
- iss_valid iss_rd=7, then rs1=7 -> rs1_busy=1; req0 rd=7 granted -> rs1_busy=0 next cycle.
- Same cycle iss_rd=3 and granted writeback rd=3 (pending) -> pending[3] remains 1; rs2=3 gives rs2_busy=1.
- Assert rst with req0 valid and pending[4]=1 -> next cycle rf_wen=0, rs1_busy(4)=0, last_grant=1.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, with a
// per-register pending scoreboard for RAW stalls. Optional trace: WB_TRACE_EN.
module regfile_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [ADDR_WIDTH-1:0] req0_rd,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ADDR_WIDTH-1:0] req1_rd,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_data,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic [ADDR_WIDTH-1:0] rs1,
  input  logic [ADDR_WIDTH-1:0] rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  last_grant
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic                  grant0;
  logic                  grant1;
  logic                  grant_any;
  logic [ADDR_WIDTH-1:0] g_rd;
  logic [DATA_WIDTH-1:0] g_data;
  logic [NREG-1:0]       pending;
  logic [NREG-1:0]       pending_nxt;

  // On a tie the port that did not win last time goes first.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  assign grant_any  = grant0 | grant1;
  assign g_rd       = grant1 ? req1_rd   : req0_rd;
  assign g_data     = grant1 ? req1_data : req0_data;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Issue is applied after the writeback clear so a newer producer keeps the bit.
  always_comb begin
    pending_nxt = pending;
    if (grant_any && (g_rd != '0))
      pending_nxt[g_rd] = 1'b0;
    if (iss_valid && (iss_rd != '0))
      pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen     <= 1'b0;
      rf_rd      <= '0;
      rf_data    <= '0;
      last_grant <= 1'b1;
      pending    <= '0;
    end else begin
      if (grant_any) begin
        rf_wen     <= (g_rd != '0);
        rf_rd      <= g_rd;
        rf_data    <= g_data;
        last_grant <= grant1;
      end else begin
        rf_wen <= 1'b0;
      end
      pending <= pending_nxt;
    end
  end

  assign rs1_busy = (rs1 != '0) && pending[rs1];
  assign rs2_busy = (rs2 != '0) && pending[rs2];

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (!rst && grant_any) begin
      $display("wb x%0d <= %x (port %0d)", g_rd, g_data, grant1);
      if ((g_rd != '0) && !pending[g_rd])
        $display("WB WARN: x%0d not pending", g_rd);
    end
  end
`else
  // Trace disabled: no simulation output.
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: table of per-cycle vectors plus a
// scoreboard of expected register-file outputs, and a hand-written reset sequence.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_rd, req1_rd;
  logic [31:0] req0_data, req1_data;
  logic        rf_wen;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        iss_valid;
  logic [4:0]  iss_rd, rs1, rs2;
  logic        rs1_busy, rs2_busy, last_grant;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rd(req1_rd), .req1_data(req1_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .last_grant(last_grant)
  );

  typedef struct {
    logic        r0v; logic [4:0] r0rd; logic [31:0] r0d;
    logic        r1v; logic [4:0] r1rd; logic [31:0] r1d;
    logic        iv;  logic [4:0] ird;
    logic [4:0]  s1;  logic [4:0] s2;
    logic        e_rdy0; logic e_rdy1; logic e_b1; logic e_b2;
  } vec_t;

  typedef struct {
    logic wen; logic [4:0] rd; logic [31:0] data; logic lg;
  } rf_exp_t;

  localparam int NV = 17;
  vec_t    vec [NV];
  rf_exp_t sb_q[$];
  rf_exp_t m, e;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_rd = 0; req0_data = 0;
    req1_valid = 0; req1_rd = 0; req1_data = 0;
    iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //            r0v r0rd r0d     r1v r1rd r1d     iv ird s1 s2  rdy0 rdy1 b1 b2
    vec[0]  = '{1, 5, 32'h11,   0, 0, 32'h0,    0, 0,  0, 0,  1, 0, 0, 0};
    vec[1]  = '{0, 0, 32'h0,    1, 0, 32'hFF,   0, 0,  0, 0,  0, 1, 0, 0};
    vec[2]  = '{1, 1, 32'hA,    1, 2, 32'hB,    0, 0,  0, 0,  1, 0, 0, 0};
    vec[3]  = '{0, 0, 32'h0,    1, 2, 32'hB,    0, 0,  0, 0,  0, 1, 0, 0};
    vec[4]  = '{1, 1, 32'hA1,   1, 2, 32'hB2,   0, 0,  0, 0,  1, 0, 0, 0};
    vec[5]  = '{1, 1, 32'hA1,   1, 2, 32'hB2,   0, 0,  0, 0,  0, 1, 0, 0};
    vec[6]  = '{1, 1, 32'hA1,   1, 2, 32'hB2,   0, 0,  0, 0,  1, 0, 0, 0};
    vec[7]  = '{1, 1, 32'hA1,   1, 2, 32'hB2,   0, 0,  0, 0,  0, 1, 0, 0};
    vec[8]  = '{0, 0, 32'h0,    0, 0, 32'h0,    0, 0,  0, 0,  0, 0, 0, 0};
    vec[9]  = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 7,  7, 0,  0, 0, 0, 0};
    vec[10] = '{1, 7, 32'h77,   0, 0, 32'h0,    0, 0,  7, 0,  1, 0, 1, 0};
    vec[11] = '{0, 0, 32'h0,    0, 0, 32'h0,    0, 0,  7, 0,  0, 0, 0, 0};
    vec[12] = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 3,  7, 0,  0, 0, 0, 0};
    vec[13] = '{0, 0, 32'h0,    1, 3, 32'h33,   1, 3,  7, 3,  0, 1, 0, 1};
    vec[14] = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 0,  0, 3,  0, 0, 0, 1};
    vec[15] = '{1, 3, 32'h3C,   0, 0, 32'h0,    0, 0,  0, 3,  1, 0, 0, 1};
    vec[16] = '{0, 0, 32'h0,    0, 0, 32'h0,    1, 4,  0, 3,  0, 0, 0, 0};

    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    rs1 = 5'd7; rs2 = 5'd3;
    #1;
    chk("reset rf_wen", rf_wen, 0);
    chk("reset rf_rd", rf_rd, 0);
    chk("reset rf_data", rf_data, 0);
    chk("reset last_grant", last_grant, 1);
    chk("reset rs1_busy", rs1_busy, 0);
    chk("reset rs2_busy", rs2_busy, 0);

    m = '{wen: 0, rd: 0, data: 0, lg: 1};
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      req0_valid = vec[i].r0v; req0_rd = vec[i].r0rd; req0_data = vec[i].r0d;
      req1_valid = vec[i].r1v; req1_rd = vec[i].r1rd; req1_data = vec[i].r1d;
      iss_valid = vec[i].iv; iss_rd = vec[i].ird;
      rs1 = vec[i].s1; rs2 = vec[i].s2;
      #1;
      chk($sformatf("v%0d req0_ready", i), req0_ready, vec[i].e_rdy0);
      chk($sformatf("v%0d req1_ready", i), req1_ready, vec[i].e_rdy1);
      chk($sformatf("v%0d rs1_busy", i), rs1_busy, vec[i].e_b1);
      chk($sformatf("v%0d rs2_busy", i), rs2_busy, vec[i].e_b2);
      if (vec[i].e_rdy0) begin
        m.wen = (vec[i].r0rd != 0); m.rd = vec[i].r0rd; m.data = vec[i].r0d; m.lg = 0;
      end else if (vec[i].e_rdy1) begin
        m.wen = (vec[i].r1rd != 0); m.rd = vec[i].r1rd; m.data = vec[i].r1d; m.lg = 1;
      end else begin
        m.wen = 0;
      end
      sb_q.push_back(m);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL v%0d scoreboard: queue empty, expected one entry", i);
      end else begin
        e = sb_q.pop_front();
        chk($sformatf("v%0d rf_wen", i), rf_wen, e.wen);
        chk($sformatf("v%0d rf_rd", i), rf_rd, e.rd);
        chk($sformatf("v%0d rf_data", i), rf_data, e.data);
        chk($sformatf("v%0d last_grant", i), last_grant, e.lg);
      end
    end

    // Reset with a request in flight and x4 pending: everything must clear.
    @(negedge clk);
    idle_inputs();
    rst = 1;
    req0_valid = 1; req0_rd = 5'd9; req0_data = 32'h99;
    rs1 = 5'd4;
    #1;
    chk("pre-reset rs1_busy x4", rs1_busy, 1);
    chk("pre-reset last_grant", last_grant, 0);
    @(posedge clk);
    #1;
    chk("rst rf_wen", rf_wen, 0);
    chk("rst rf_rd", rf_rd, 0);
    chk("rst rf_data", rf_data, 0);
    chk("rst last_grant", last_grant, 1);
    chk("rst rs1_busy x4", rs1_busy, 0);
    @(negedge clk);
    rst = 0;
    req0_valid = 0;
    @(posedge clk);
    #1;
    chk("post-rst rf_wen", rf_wen, 0);
    chk("post-rst rs1_busy x4", rs1_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
